// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator sequencer: opcodes, accumulator/mux selects,
// ALU operations, FSM states and decoded instruction classes.
package acc_pkg;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpLdi = 4'h1;
   localparam logic [3:0] OpLdr = 4'h2;
   localparam logic [3:0] OpStr = 4'h3;
   localparam logic [3:0] OpAdd = 4'h4;
   localparam logic [3:0] OpSub = 4'h5;
   localparam logic [3:0] OpAnd = 4'h6;
   localparam logic [3:0] OpOr  = 4'h7;
   localparam logic [3:0] OpXor = 4'h8;
   localparam logic [3:0] OpLdm = 4'h9;
   localparam logic [3:0] OpStm = 4'hA;
   localparam logic [3:0] OpJz  = 4'hB;
   localparam logic [3:0] OpJnz = 4'hC;
   localparam logic [3:0] OpHlt = 4'hD;

   localparam logic [1:0] SelMuxToAcc = 2'b00;
   localparam logic [1:0] SelAluToAcc = 2'b01;
   localparam logic [1:0] SelRegToMux = 2'b10;
   localparam logic [1:0] SelImmToMux = 2'b11;

   localparam logic [2:0] AluAdd = 3'd0;
   localparam logic [2:0] AluSub = 3'd1;
   localparam logic [2:0] AluAnd = 3'd2;
   localparam logic [2:0] AluOr  = 3'd3;
   localparam logic [2:0] AluXor = 3'd4;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StStage,
      StCommit,
      StMemWait,
      StHalt
   } state_e;

   typedef enum logic [3:0] {
      ClsNop,
      ClsLdi,
      ClsLdr,
      ClsStr,
      ClsAlu,
      ClsLdm,
      ClsStm,
      ClsJz,
      ClsJnz,
      ClsHlt
   } cls_e;

endpackage

// File: rtl/acc_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and illegal-opcode flag.
module acc_decode
   import acc_pkg::*;
(
   input  logic [3:0] opcode,
   output cls_e       cls,
   output logic [2:0] alu_op,
   output logic       illegal
);

   always_comb begin
      cls     = ClsNop;
      alu_op  = AluAdd;
      illegal = 1'b0;
      case (opcode)
         OpNop: cls = ClsNop;
         OpLdi: cls = ClsLdi;
         OpLdr: cls = ClsLdr;
         OpStr: cls = ClsStr;
         OpAdd: begin cls = ClsAlu; alu_op = AluAdd; end
         OpSub: begin cls = ClsAlu; alu_op = AluSub; end
         OpAnd: begin cls = ClsAlu; alu_op = AluAnd; end
         OpOr:  begin cls = ClsAlu; alu_op = AluOr;  end
         OpXor: begin cls = ClsAlu; alu_op = AluXor; end
         OpLdm: cls = ClsLdm;
         OpStm: cls = ClsStm;
         OpJz:  cls = ClsJz;
         OpJnz: cls = ClsJnz;
         OpHlt: cls = ClsHlt;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/acc_sequencer.sv
// Multi-cycle accumulator control sequencer with registered control outputs.
// Macro ACC_SEQUENCER_BRANCH_EN enables JZ/JNZ; without it opcodes B/C behave as NOP.
module acc_sequencer
   import acc_pkg::*;
#(
   parameter int unsigned PC_W = 8
) (
   input  logic            clk,
   input  logic            clb,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [7:0]      instr,
   output logic            mem_req,
   output logic            mem_we,
   input  logic            mem_ready,
   input  logic            alu_zero,
   output logic [1:0]      sel_acc,
   output logic            load_acc,
   output logic [3:0]      imm,
   output logic [3:0]      reg_sel,
   output logic            reg_we,
   output logic [2:0]      alu_op,
   output logic [PC_W-1:0] pc,
   output logic            halted
);

   state_e          state_q, state_d;
   logic [7:0]      instr_q, instr_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            instr_ready_q, instr_ready_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [1:0]      sel_acc_q, sel_acc_d;
   logic            load_acc_q, load_acc_d;
   logic [3:0]      imm_q, imm_d;
   logic [3:0]      reg_sel_q, reg_sel_d;
   logic            reg_we_q, reg_we_d;
   logic [2:0]      alu_op_q, alu_op_d;
   logic            halted_q, halted_d;

   logic            handshake;
   logic            taken;
   cls_e            cls;
   logic [2:0]      dec_alu_op;
   logic            illegal;
   logic [3:0]      operand;
   logic [PC_W-1:0] offset;

   // Decode the instruction that will be current next cycle so outputs can be registered.
   acc_decode u_decode (
      .opcode  (instr_d[7:4]),
      .cls     (cls),
      .alu_op  (dec_alu_op),
      .illegal (illegal)
   );

   assign handshake = instr_ready_q && instr_valid;
   assign instr_d   = handshake ? instr : instr_q;
   assign operand   = instr_d[3:0];
   assign offset    = {{(PC_W-4){instr_q[3]}}, instr_q[3:0]};

`ifdef ACC_SEQUENCER_BRANCH_EN
   assign taken = ((cls == ClsJz) && alu_zero) || ((cls == ClsJnz) && !alu_zero);
`else
   logic unused_alu_zero;
   assign unused_alu_zero = alu_zero;
   assign taken = 1'b0;
`endif

   // Next state and pc
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: begin
            if (handshake) begin
               state_d = StDecode;
               pc_d    = pc_q + PC_W'(1);
            end
         end
         StDecode: begin
            if (illegal || (cls == ClsHlt)) begin
               state_d = StHalt;
            end else begin
               case (cls)
                  ClsLdi, ClsLdr, ClsAlu: state_d = StStage;
                  ClsStr:                 state_d = StCommit;
                  ClsLdm, ClsStm:         state_d = StMemWait;
                  default:                state_d = StFetch;
               endcase
               if (taken) pc_d = pc_q + offset;
            end
         end
         StStage:  state_d = StCommit;
         StCommit: state_d = StFetch;
         StMemWait: begin
            if (mem_ready) state_d = (cls == ClsLdm) ? StCommit : StFetch;
         end
         StHalt:   state_d = StHalt;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are a function of the state being entered, so each flop holds its state's value.
   always_comb begin
      instr_ready_d = (state_d == StFetch);
      halted_d      = (state_d == StHalt);
      mem_req_d     = 1'b0;
      mem_we_d      = 1'b0;
      sel_acc_d     = SelMuxToAcc;
      load_acc_d    = 1'b0;
      imm_d         = 4'h0;
      reg_sel_d     = 4'h0;
      reg_we_d      = 1'b0;
      alu_op_d      = AluAdd;
      case (state_d)
         StStage: begin
            case (cls)
               ClsLdi: begin
                  sel_acc_d = SelImmToMux;
                  imm_d     = operand;
               end
               ClsLdr: begin
                  sel_acc_d = SelRegToMux;
                  reg_sel_d = operand;
               end
               ClsAlu: begin
                  reg_sel_d = operand;
                  alu_op_d  = dec_alu_op;
               end
               default: ;
            endcase
         end
         StCommit: begin
            case (cls)
               ClsLdi: begin
                  load_acc_d = 1'b1;
                  imm_d      = operand;
               end
               ClsLdr, ClsLdm: begin
                  load_acc_d = 1'b1;
                  reg_sel_d  = operand;
               end
               ClsAlu: begin
                  sel_acc_d  = SelAluToAcc;
                  load_acc_d = 1'b1;
                  reg_sel_d  = operand;
                  alu_op_d   = dec_alu_op;
               end
               ClsStr: begin
                  reg_we_d  = 1'b1;
                  reg_sel_d = operand;
               end
               default: ;
            endcase
         end
         StMemWait: begin
            mem_req_d = 1'b1;
            mem_we_d  = (cls == ClsStm);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clb) begin
         state_q       <= StIdle;
         instr_q       <= 8'h00;
         pc_q          <= '0;
         instr_ready_q <= 1'b0;
         halted_q      <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         sel_acc_q     <= SelMuxToAcc;
         load_acc_q    <= 1'b0;
         imm_q         <= 4'h0;
         reg_sel_q     <= 4'h0;
         reg_we_q      <= 1'b0;
         alu_op_q      <= AluAdd;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         instr_ready_q <= instr_ready_d;
         halted_q      <= halted_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         sel_acc_q     <= sel_acc_d;
         load_acc_q    <= load_acc_d;
         imm_q         <= imm_d;
         reg_sel_q     <= reg_sel_d;
         reg_we_q      <= reg_we_d;
         alu_op_q      <= alu_op_d;
      end
   end

   assign instr_ready = instr_ready_q;
   assign halted      = halted_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign sel_acc     = sel_acc_q;
   assign load_acc    = load_acc_q;
   assign imm         = imm_q;
   assign reg_sel     = reg_sel_q;
   assign reg_we      = reg_we_q;
   assign alu_op      = alu_op_q;
   assign pc          = pc_q;

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port clb  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports instr_valid/instr_ready  input/output  1/1  instruction-fetch handshake; transfer when both high.
REQ-005 SHALL have port instr  input  8  [7:4] opcode, [3:0] operand (imm, reg index or signed offset).
REQ-006 SHALL have ports mem_req/mem_we/mem_ready  output/output/input  1/1/1  data-memory handshake.
REQ-007 SHALL have port alu_zero  input  1  zero flag of current ALU result.
REQ-008 SHALL have outputs sel_acc 2, load_acc 1, imm 4, reg_sel 4, reg_we 1, alu_op 3, pc PC_W, halted 1.

Function
REQ-009 SHALL run FSM states IDLE, FETCH, DECODE, STAGE, COMMIT, MEMWAIT, HALT.
REQ-010 SHALL leave IDLE for FETCH the cycle after reset deasserts.
REQ-011 SHALL hold instr_ready=1 only in FETCH; on handshake latch instr, pc<=pc+1 (wraps modulo 2^PC_W), go DECODE.
REQ-012 SHALL use sel_acc encoding: 10 reg->mux, 11 imm->mux, 00 mux->acc, 01 alu->acc; load_acc pulses one cycle with the 00/01 select.
REQ-013 SHALL decode: 0 NOP, 1 LDI, 2 LDR, 3 STR, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 LDM, A STM, B JZ, C JNZ, D HLT, E/F illegal.
REQ-014 LDI: STAGE sel_acc=11 imm=operand; COMMIT sel_acc=00 load_acc=1; 3 cycles after fetch handshake to FETCH.
REQ-015 LDR: STAGE sel_acc=10 reg_sel=operand; COMMIT sel_acc=00 load_acc=1.
REQ-016 STR: COMMIT reg_we=1 reg_sel=operand for exactly one cycle; load_acc=0.
REQ-017 ADD..XOR: STAGE reg_sel=operand, alu_op=opcode-4; COMMIT sel_acc=01 load_acc=1, alu_op held.
REQ-018 LDM/STM: mem_req=1 (mem_we=1 for STM) in MEMWAIT until mem_ready=1; LDM then COMMIT sel_acc=00 load_acc=1 with reg_sel=operand; no timeout.
REQ-019 mem_req/mem_we SHALL stay stable while waiting; mem_ready outside MEMWAIT ignored.
REQ-020 JZ/JNZ: sample alu_zero in DECODE; if taken pc<=pc+sign_extend(operand), modulo 2^PC_W; not taken: no change; return to FETCH.
REQ-021 HLT and illegal opcodes SHALL enter HALT; halted=1, instr_ready=0; only reset exits.
REQ-022 NOP SHALL return DECODE->FETCH with no strobes.
REQ-023 All strobes (load_acc, reg_we, mem_req, mem_we) SHALL be 0 in IDLE, FETCH, HALT.

Reset
REQ-024 clb=1 at an edge SHALL force IDLE, pc=0, halted=0, all strobes 0, sel_acc=00, imm=0, reg_sel=0, alu_op=0, from any state incl. mid-MEMWAIT.
REQ-025 Reset SHALL take priority over any simultaneous handshake completion.

Configuration
REQ-026 Macro ACC_SEQUENCER_BRANCH_EN: defined -> JZ/JNZ per REQ-020; undefined -> opcodes B/C execute as NOP, pc increments only.

Structure
REQ-027 Shared package acc_pkg SHALL hold opcode constants, sel_acc encodings, alu_op encodings, FSM state enum.
REQ-028 One sub-module acc_decode (combinational opcode -> class/alu_op/illegal) is natural; FSM stays in acc_sequencer.

Verification
REQ-029 Reset then instr=0x15 -> STAGE sel_acc=11 imm=5; COMMIT sel_acc=00 load_acc=1; pc=1.
REQ-030 instr=0x43 -> reg_sel=3, alu_op=0 in STAGE; COMMIT sel_acc=01 load_acc=1 for one cycle.
REQ-031 instr=0x92, mem_ready low 4 cycles -> mem_req held 5 cycles, mem_we=0, then load_acc=1 once.
REQ-032 pc=0x10, alu_zero=1, instr=0xBE -> pc=0x0F (0x11-2); with macro undefined pc=0x11.
REQ-033 pc=0xFF fetch -> pc wraps to 0x00; instr=0xF0 -> halted=1, instr_ready stays 0.
REQ-034 clb=1 asserted mid-MEMWAIT -> next cycle mem_req=0, pc=0, state IDLE.
